ahb_apb_bridge_monitor: RTL and testbench

AHB_APB_BRIDGE_MONITOR -- requirements
Module: ahb_apb_bridge_monitor

---
 rtl/ahb_apb_mon_pkg.sv | 27 ++
 rtl/ahb_apb_mon_sat_cnt.sv | 31 +++
 rtl/ahb_apb_bridge_monitor.sv | 134 +++++++++++++
 tb/tb_ahb_apb_bridge_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_mon_pkg.sv
// Shared definitions for the AHB-to-APB bridge monitor.
//   apb_phase_e : phase register encoding (previous cycle's APB class)
//   NUM_CHECKS  : width of err_pulse / err_sticky
//   CHK_*       : bit index of each protocol check
//   HRESP_*     : AHB response encodings used by the SLVERR check
package ahb_apb_mon_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_WAIT  = 2'd2
  } apb_phase_e;

  localparam int NUM_CHECKS = 7;

  localparam int CHK_ONEHOT    = 0;
  localparam int CHK_EN_NO_SEL = 1;
  localparam int CHK_PHASE     = 2;
  localparam int CHK_STABLE    = 3;
  localparam int CHK_RDATA     = 4;
  localparam int CHK_SLVERR    = 5;
  localparam int CHK_TIMEOUT   = 6;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_apb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count up by one (held at MAX once reached)
//   clr      : synchronous clear, has priority over inc
//   count    : current value
module ahb_apb_mon_sat_cnt #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != MAX)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ahb_apb_bridge_monitor.sv
// Passive protocol monitor for the APB side of an AHB-to-APB bridge.
// Inputs : HCLK, HRESET (async, active-high), err_clear, the AHB request and
//          bridge response signals, and the full APB bus (all observe-only).
// Outputs: err_pulse  - one-cycle flag per check, the cycle after a violation
//          err_sticky - latched copy of err_pulse, cleared by err_clear
//          rd_count / wr_count - saturating counts of completed APB transfers
//          apb_state  - phase register (class of the previous cycle)
// APB handshake: a transfer completes on a cycle where PSEL is non-zero,
// PENABLE is high and PREADY is high; PENABLE with PREADY low is a wait state.
module ahb_apb_bridge_monitor
  import ahb_apb_mon_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  err_clear,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic [1:0]            HRESP,
  input  logic                  HREADY_OUT,
  input  logic [NUM_SLAVES-1:0] PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [6:0]            err_pulse,
  output logic [6:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [1:0]            apb_state
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  // AHB request side is observed only through the bridge response signals.
  logic unused_ahb;
  assign unused_ahb = ^{HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY_OUT};

  logic sel, setup, access, done, wait_cyc;
  assign sel      = |PSEL;
  assign setup    = sel & ~PENABLE;
  assign access   = sel & PENABLE;
  assign done     = access & PREADY;
  assign wait_cyc = access & ~PREADY;

  apb_phase_e              state_q, state_d;
  logic [NUM_SLAVES-1:0]   cap_psel_q;
  logic [ADDR_WIDTH-1:0]   cap_paddr_q;
  logic                    cap_pwrite_q;
  logic [DATA_WIDTH-1:0]   cap_pwdata_q;
  logic                    slverr_pend_q, slverr_pend_d;
  logic [NUM_CHECKS-1:0]   viol, err_pulse_q, err_sticky_q;
  logic [WAIT_W-1:0]       wait_cnt;

  always_comb begin
    state_d = PH_IDLE;
    if (setup)         state_d = PH_SETUP;
    else if (wait_cyc) state_d = PH_WAIT;
  end

  // SLVERR is only an error if the bridge fails to answer ERROR in both the
  // done cycle and the one after, so the done-cycle half is held here.
  assign slverr_pend_d = done & PSLVERR & (HRESP != HRESP_ERROR);

  always_comb begin
    viol = '0;
    viol[CHK_ONEHOT]    = (PSEL & (PSEL - NUM_SLAVES'(1))) != '0;
    viol[CHK_EN_NO_SEL] = PENABLE & ~sel;
    viol[CHK_PHASE]     = (state_q == PH_IDLE) ? access : ~access;
    viol[CHK_STABLE]    = (state_q != PH_IDLE) & access &
                          ((PSEL != cap_psel_q) | (PADDR != cap_paddr_q) |
                           (PWRITE != cap_pwrite_q) |
                           (PWRITE & (PWDATA != cap_pwdata_q)));
    viol[CHK_RDATA]     = done & ~PWRITE & (HRDATA != PRDATA);
    viol[CHK_SLVERR]    = slverr_pend_q & (HRESP != HRESP_ERROR);
    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES; the
    // counter then sits at its maximum so this compare cannot match again.
    viol[CHK_TIMEOUT]   = wait_cyc & (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= PH_IDLE;
      cap_psel_q    <= '0;
      cap_paddr_q   <= '0;
      cap_pwrite_q  <= 1'b0;
      cap_pwdata_q  <= '0;
      slverr_pend_q <= 1'b0;
      err_pulse_q   <= '0;
      err_sticky_q  <= '0;
    end else begin
      state_q       <= state_d;
      slverr_pend_q <= slverr_pend_d;
      if (setup) begin
        cap_psel_q   <= PSEL;
        cap_paddr_q  <= PADDR;
        cap_pwrite_q <= PWRITE;
        cap_pwdata_q <= PWDATA;
      end
      err_pulse_q  <= viol;
      // A violation in the clearing cycle keeps its bit set.
      err_sticky_q <= (err_clear ? '0 : err_sticky_q) | viol;
    end
  end

  ahb_apb_mon_sat_cnt #(.WIDTH(WAIT_W), .MAX(WAIT_W'(TIMEOUT_CYCLES))) u_wait_cnt (
    .clk(HCLK), .rst(HRESET), .inc(wait_cyc), .clr(~wait_cyc), .count(wait_cnt)
  );

  ahb_apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk(HCLK), .rst(HRESET), .inc(done & ~PWRITE), .clr(1'b0), .count(rd_count)
  );

  ahb_apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk(HCLK), .rst(HRESET), .inc(done & PWRITE), .clr(1'b0), .count(wr_count)
  );

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign apb_state  = state_q;

endmodule

// File: tb/tb_ahb_apb_bridge_monitor.sv
module tb_ahb_apb_bridge_monitor;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        err_clear;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREADY_OUT;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [6:0]  err_pulse;
  logic [6:0]  err_sticky;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [1:0]  apb_state;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  ahb_apb_bridge_monitor dut (
    .HCLK(HCLK), .HRESET(HRESET), .err_clear(err_clear),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY_OUT(HREADY_OUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .rd_count(rd_count), .wr_count(wr_count), .apb_state(apb_state)
  );

  // ---------------- driver tasks ----------------
  // Inputs set before step() describe one bus cycle; after step() the
  // registered outputs reflect that cycle.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    PSEL = 4'b0000; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    HRESP = 2'b00; err_clear = 1'b0;
  endtask

  task automatic drive_setup(input logic [3:0] sel, input logic [31:0] addr,
                             input logic wr, input logic [31:0] wdata);
    PSEL = sel; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    PREADY = 1'b0;
  endtask

  task automatic drive_access(input logic rdy);
    PENABLE = 1'b1; PREADY = rdy;
  endtask

  task automatic clear_sticky();
    bus_idle();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    HRESET = 1'b1;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
    HRDATA = '0; HREADY_OUT = 1'b1; PADDR = '0; PWRITE = 1'b0; PWDATA = '0;
    PRDATA = '0;
    bus_idle();
    step(); step();
    checks++;
    if ({err_pulse, err_sticky, rd_count, wr_count, apb_state} !== '0) begin
      failures++;
      $display("FAIL reset: pulse=%b sticky=%b rd=%0d wr=%0d st=%0d expected all 0",
               err_pulse, err_sticky, rd_count, wr_count, apb_state);
    end
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_legal_write();
    drive_setup(4'b0010, 32'h100, 1'b1, 32'hA5A5_0000);
    step();
    checks++;
    if (err_pulse !== 7'b0 || apb_state !== 2'd1) begin
      failures++;
      $display("FAIL write_setup: pulse=%b st=%0d expected pulse=0 st=1", err_pulse, apb_state);
    end
    drive_access(1'b1);
    step();
    checks++;
    if (err_pulse !== 7'b0 || wr_count !== 16'd1 || apb_state !== 2'd0) begin
      failures++;
      $display("FAIL write_done: pulse=%b wr=%0d st=%0d expected pulse=0 wr=1 st=0",
               err_pulse, wr_count, apb_state);
    end
    bus_idle();
    step();
  endtask

  task automatic test_read_wait(input logic [31:0] hrd, input logic [6:0] exp_pulse,
                                input logic [15:0] exp_rd);
    drive_setup(4'b0001, 32'h200, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive_access(1'b0);
      step();
      checks++;
      if (err_pulse !== 7'b0 || apb_state !== 2'd2) begin
        failures++;
        $display("FAIL read_wait%0d: pulse=%b st=%0d expected pulse=0 st=2", i, err_pulse, apb_state);
      end
    end
    PRDATA = 32'h1234; HRDATA = hrd;
    drive_access(1'b1);
    step();
    checks++;
    if (err_pulse !== exp_pulse || rd_count !== exp_rd || apb_state !== 2'd0) begin
      failures++;
      $display("FAIL read_done: pulse=%b rd=%0d st=%0d expected pulse=%b rd=%0d st=0",
               err_pulse, rd_count, apb_state, exp_pulse, exp_rd);
    end
    bus_idle();
    step();
    checks++;
    if (err_pulse !== 7'b0 || err_sticky !== exp_pulse) begin
      failures++;
      $display("FAIL read_after: pulse=%b sticky=%b expected pulse=0 sticky=%b",
               err_pulse, err_sticky, exp_pulse);
    end
    HRDATA = PRDATA;
  endtask

  task automatic test_stable_onehot();
    clear_sticky();
    checks++;
    if (err_sticky !== 7'b0) begin
      failures++;
      $display("FAIL clear: sticky=%b expected 0", err_sticky);
    end
    drive_setup(4'b0010, 32'h100, 1'b0, 32'h0);
    step();
    drive_access(1'b0);
    step();
    PADDR = 32'h104;
    step();
    checks++;
    if (err_pulse !== 7'b0001000) begin
      failures++;
      $display("FAIL stable_paddr: pulse=%b expected 0001000", err_pulse);
    end
    PADDR = 32'h100;
    drive_access(1'b1);
    step();
    checks++;
    if (err_pulse !== 7'b0) begin
      failures++;
      $display("FAIL stable_restored: pulse=%b expected 0", err_pulse);
    end
    bus_idle();
    step();
    drive_setup(4'b0011, 32'h300, 1'b1, 32'h55);
    step();
    checks++;
    if (err_pulse !== 7'b0000001) begin
      failures++;
      $display("FAIL onehot: pulse=%b expected 0000001", err_pulse);
    end
    bus_idle();
    step();
  endtask

  task automatic test_timeout();
    int n_to;
    n_to = 0;
    clear_sticky();
    drive_setup(4'b0001, 32'h400, 1'b0, 32'h0);
    step();
    drive_access(1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (err_pulse[6]) n_to++;
      checks++;
      if (err_pulse !== ((i == 16) ? 7'b1000000 : 7'b0)) begin
        failures++;
        $display("FAIL timeout_cycle%0d: pulse=%b expected %b", i, err_pulse,
                 (i == 16) ? 7'b1000000 : 7'b0);
      end
    end
    checks++;
    if (n_to != 1) begin
      failures++;
      $display("FAIL timeout_count: pulses=%0d expected 1", n_to);
    end
    drive_access(1'b1);
    step();
    bus_idle();
    step();
  endtask

  task automatic test_slverr();
    // Bridge answers ERROR the cycle after done: not a violation.
    drive_setup(4'b0100, 32'h500, 1'b1, 32'h1);
    step();
    drive_access(1'b1); PSLVERR = 1'b1; HRESP = 2'b00;
    step();
    bus_idle(); HRESP = 2'b01;
    step();
    HRESP = 2'b00;
    step();
    checks++;
    if (err_pulse !== 7'b0) begin
      failures++;
      $display("FAIL slverr_ok: pulse=%b expected 0", err_pulse);
    end
    // Bridge answers OKAY in both cycles: violation reported two cycles on.
    drive_setup(4'b0100, 32'h504, 1'b1, 32'h2);
    step();
    drive_access(1'b1); PSLVERR = 1'b1; HRESP = 2'b00;
    step();
    checks++;
    if (err_pulse !== 7'b0) begin
      failures++;
      $display("FAIL slverr_early: pulse=%b expected 0", err_pulse);
    end
    bus_idle();
    step();
    checks++;
    if (err_pulse !== 7'b0100000) begin
      failures++;
      $display("FAIL slverr_bad: pulse=%b expected 0100000", err_pulse);
    end
    step();
  endtask

  task automatic test_clear_collision();
    // Access straight from IDLE is a PHASE error, coinciding with err_clear.
    PSEL = 4'b0001; PENABLE = 1'b1; PREADY = 1'b1; PWRITE = 1'b1;
    err_clear = 1'b1;
    step();
    checks++;
    if (err_pulse !== 7'b0000100 || err_sticky !== 7'b0000100) begin
      failures++;
      $display("FAIL clear_collision: pulse=%b sticky=%b expected 0000100/0000100",
               err_pulse, err_sticky);
    end
    bus_idle();
    step();
    checks++;
    if (err_sticky !== 7'b0000100) begin
      failures++;
      $display("FAIL clear_hold: sticky=%b expected 0000100", err_sticky);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    bad = 0;
    drive_setup(4'b1000, 32'h600, 1'b0, 32'h0);
    step();
    drive_access(1'b0);
    for (int i = 0; i < 10; i++) step();
    #2;
    HRESET = 1'b1;
    bus_idle();
    #1;
    checks++;
    if ({err_pulse, err_sticky, rd_count, wr_count, apb_state} !== '0) begin
      failures++;
      $display("FAIL reset_mid: pulse=%b sticky=%b rd=%0d wr=%0d st=%0d expected all 0",
               err_pulse, err_sticky, rd_count, wr_count, apb_state);
    end
    step(); step();
    HRESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (err_pulse !== 7'b0) bad++;
    end
    checks++;
    if (bad != 0 || err_sticky !== 7'b0 || rd_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_no_timeout: bad_cycles=%0d sticky=%b rd=%0d expected 0/0/0",
               bad, err_sticky, rd_count);
    end
    drive_setup(4'b0010, 32'h700, 1'b1, 32'h9);
    step();
    drive_access(1'b1);
    step();
    checks++;
    if (wr_count !== 16'd1 || err_pulse !== 7'b0) begin
      failures++;
      $display("FAIL restart: wr=%0d pulse=%b expected 1/0", wr_count, err_pulse);
    end
    bus_idle();
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_legal_write();
    test_read_wait(32'h1234, 7'b0000000, 16'd1);
    test_read_wait(32'h1235, 7'b0010000, 16'd2);
    test_stable_onehot();
    test_timeout();
    test_slverr();
    test_clear_collision();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
